vga_mem_arbiter: RTL and testbench

Shares one single-port synchronous framebuffer RAM between the VGA scanout line prefetcher and a pixel writer port.
- Scanout issues fixed-length read bursts and gets priority. The writer issues single-word writes into the gaps.
- A wait counter stops the writer from starving. A scanout urgent flag overrides the counter when the line buffer is close to underrun.
- Sits between the scanout/line-buffer logic and the framebuffer RAM. Runs on the pixel-domain clock.

---
 rtl/vga_mem_arbiter.sv | 105 ++++++++++
 tb/tb_vga_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Framebuffer RAM arbiter: scanout read bursts take priority, and the pixel writer fills the gaps between them.
// A wait counter lets a starved writer win a decision slot unless scanout flags urgent.
module vga_mem_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 6,
  parameter int BURST       = 8,
  parameter int WR_MAX_WAIT = 16
) (
  input  logic              MainClkSrc,
  input  logic              Reset,
  input  logic              ScanReq,
  input  logic              ScanUrgent,
  input  logic [ADDR_W-1:0] ScanAddr,
  output logic              ScanAck,
  output logic [DATA_W-1:0] ScanData,
  output logic              ScanValid,
  output logic              ScanLast,
  input  logic              WrReq,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic              WrAck,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  input  logic [DATA_W-1:0] MemRdData
);
  localparam int BW = $clog2(BURST);
  localparam int WW = $clog2(WR_MAX_WAIT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [WW-1:0] WAIT_SAT  = WW'(WR_MAX_WAIT);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            state_q;
  logic [BW-1:0]     beat_q;
  logic [WW-1:0]     wait_q, wait_d;
  logic              mem_en_q, mem_we_q, valid_q, last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              final_beat, slot, writer_pri, scan_grant, wr_grant;

  // The final beat doubles as a decision slot, so back-to-back bursts leave no bubble.
  assign final_beat = (state_q == S_BURST) && (beat_q == LAST_BEAT);
  assign slot       = (state_q == S_IDLE) || final_beat;
  assign writer_pri = (wait_q == WAIT_SAT) && !ScanUrgent;
  assign scan_grant = !Reset && slot && ScanReq && !(WrReq && writer_pri);
  assign wr_grant   = !Reset && slot && WrReq && !scan_grant;

  always_comb begin
    wait_d = '0;
    if (WrReq && !wr_grant)
      wait_d = (wait_q == WAIT_SAT) ? wait_q : wait_q + WW'(1);
  end

  always_ff @(posedge MainClkSrc) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      wait_q   <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      valid_q <= mem_en_q && !mem_we_q;
      last_q  <= final_beat;
      if (scan_grant) begin
        state_q  <= S_BURST;
        beat_q   <= '0;
        mem_en_q <= 1'b1;
        mem_we_q <= 1'b0;
        addr_q   <= ScanAddr;
      end else if (state_q == S_BURST && !final_beat) begin
        beat_q   <= beat_q + BW'(1);
        addr_q   <= addr_q + ADDR_W'(1);
        mem_en_q <= 1'b1;
        mem_we_q <= 1'b0;
      end else if (wr_grant) begin
        state_q  <= S_IDLE;
        mem_en_q <= 1'b1;
        mem_we_q <= 1'b1;
        addr_q   <= WrAddr;
        wdata_q  <= WrData;
      end else begin
        state_q  <= S_IDLE;
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end
    end
  end

  assign ScanAck   = scan_grant;
  assign WrAck     = wr_grant;
  assign MemEn     = mem_en_q;
  assign MemWe     = mem_we_q;
  assign MemAddr   = addr_q;
  assign MemWrData = wdata_q;
  assign ScanValid = valid_q;
  assign ScanLast  = last_q;
  assign ScanData  = MemRdData;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: a queue-of-scheduled-RAM-cycles model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_vga_mem_arbiter;
  localparam int BURST = 8;
  localparam int MAXW  = 16;

  logic        clk = 1'b0;
  logic        Reset, ScanReq, ScanUrgent, WrReq;
  logic [14:0] ScanAddr, WrAddr, MemAddr;
  logic [5:0]  WrData, ScanData, MemWrData, MemRdData;
  logic        ScanAck, ScanValid, ScanLast, WrAck, MemEn, MemWe;

  vga_mem_arbiter #(.ADDR_W(15), .DATA_W(6), .BURST(BURST), .WR_MAX_WAIT(MAXW)) dut (
    .MainClkSrc(clk), .Reset(Reset), .ScanReq(ScanReq), .ScanUrgent(ScanUrgent),
    .ScanAddr(ScanAddr), .ScanAck(ScanAck), .ScanData(ScanData), .ScanValid(ScanValid),
    .ScanLast(ScanLast), .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData), .WrAck(WrAck),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRdData(MemRdData));

  always #5 clk = ~clk;

  // Framebuffer RAM driven by the DUT
  logic [5:0] ram [0:32767];
  logic [5:0] rd_q;
  assign MemRdData = rd_q;
  always @(posedge clk)
    if (MemEn) begin
      if (MemWe) ram[MemAddr] <= MemWrData;
      else       rd_q <= ram[MemAddr];
    end

  int nchk = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a queue of RAM cycles already committed for the coming edges.
  typedef struct packed {
    logic        en;
    logic        we;
    logic [14:0] addr;
    logic [5:0]  data;
    logic        last;
  } op_t;

  op_t        sched[$];
  op_t        cur, prv, o;
  logic [5:0] mmem [0:32767];
  logic [5:0] exp_rd;
  int         wcnt = 0;
  int         cyc = 0;
  bit         armed = 0;
  bit         eScanAck, eWrAck;

  initial for (int i = 0; i < 32768; i++) begin
    ram[i]  = 6'(i * 5 + 3);
    mmem[i] = 6'(i * 5 + 3);
  end

  always @(posedge clk) begin
    cyc++;
    if (Reset) begin
      armed = 1;
      sched.delete();
      cur  = '0;
      prv  = '0;
      wcnt = 0;
    end else if (armed) begin
      if (eScanAck) begin
        for (int i = 0; i < BURST; i++) begin
          o = '0;
          o.en = 1'b1;
          o.addr = 15'(ScanAddr + i);
          o.last = (i == BURST - 1);
          sched.push_back(o);
        end
      end else if (eWrAck) begin
        o = '0;
        o.en = 1'b1;
        o.we = 1'b1;
        o.addr = WrAddr;
        o.data = WrData;
        sched.push_back(o);
      end
      if (cur.en && cur.we)  mmem[cur.addr] = cur.data;
      if (cur.en && !cur.we) exp_rd = mmem[cur.addr];
      prv = cur;
      cur = (sched.size() > 0) ? sched.pop_front() : op_t'('0);
      wcnt = (WrReq && !eWrAck) ? ((wcnt < MAXW) ? wcnt + 1 : MAXW) : 0;
    end
  end

  // Monitors feeding the directed literal checks
  logic [14:0] rdq[$];
  logic [20:0] wrq[$];
  logic [5:0]  dq[$];
  int first_v = -1, last_cyc = -1, nlast = 0;

  always @(negedge clk) begin
    if (armed) begin
      // Idle arbiter: no committed future cycles means this cycle is a decision slot.
      eScanAck = !Reset && (sched.size() == 0) && ScanReq &&
                 !(WrReq && (wcnt == MAXW) && !ScanUrgent);
      eWrAck   = !Reset && (sched.size() == 0) && WrReq && !eScanAck;
      chk("ScanAck", ScanAck, eScanAck);
      chk("WrAck", WrAck, eWrAck);
      chk("MemEn", MemEn, cur.en);
      chk("MemWe", MemWe, cur.we);
      if (cur.en) chk("MemAddr", MemAddr, cur.addr);
      if (cur.en && cur.we) chk("MemWrData", MemWrData, cur.data);
      chk("ScanValid", ScanValid, prv.en && !prv.we);
      chk("ScanLast", ScanLast, prv.last);
      if (prv.en && !prv.we) chk("ScanData", ScanData, exp_rd);

      if (MemEn && !MemWe) rdq.push_back(MemAddr);
      if (MemEn && MemWe)  wrq.push_back({MemAddr, MemWrData});
      if (ScanValid) begin
        dq.push_back(ScanData);
        if (first_v < 0) first_v = cyc;
      end
      if (ScanLast === 1'b1) begin
        nlast++;
        last_cyc = cyc;
      end
    end else begin
      eScanAck = 0;
      eWrAck   = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int t0, ack_k, nwack, drops;

  initial begin
    Reset = 1; ScanReq = 1; ScanUrgent = 0; ScanAddr = 15'h0010;
    WrReq = 0; WrAddr = '0; WrData = '0;
    tick; tick; tick;
    #1 chk("ack_gated_in_reset", ScanAck, 0);

    // Single burst from IDLE at 0x0010
    Reset = 0;
    #1 chk("t1_ack", ScanAck, 1);
    rdq.delete(); first_v = -1; nlast = 0; t0 = cyc;
    tick; ScanReq = 0;
    repeat (12) tick;
    chk("t1_nreads", rdq.size(), 8);
    chk("t1_addr0", rdq[0], 15'h0010);
    chk("t1_addr7", rdq[7], 15'h0017);
    chk("t1_first_valid", first_v - t0, 2);
    chk("t1_nlast", nlast, 1);
    chk("t1_last_pos", last_cyc - t0, 9);

    // Address wrap at the top of the framebuffer
    ScanReq = 1; ScanAddr = 15'h7FFE; rdq.delete();
    tick; ScanReq = 0;
    repeat (10) tick;
    chk("t2_nreads", rdq.size(), 8);
    chk("t2_a0", rdq[0], 15'h7FFE);
    chk("t2_a1", rdq[1], 15'h7FFF);
    chk("t2_a2", rdq[2], 15'h0000);
    chk("t2_a7", rdq[7], 15'h0005);

    // Writer alone: four back-to-back writes
    wrq.delete();
    for (int i = 0; i < 4; i++) begin
      WrReq = 1; WrAddr = 15'(15'h1230 + i); WrData = 6'(6'h21 + i);
      #1 chk("t3_wrack", WrAck, 1);
      tick;
    end
    WrReq = 0;
    tick; tick;
    chk("t3_nwrites", wrq.size(), 4);
    chk("t3_w0", wrq[0], {15'h1230, 6'h21});
    chk("t3_w3", wrq[3], {15'h1233, 6'h24});

    // Read back across the written words
    ScanReq = 1; ScanAddr = 15'h122E; dq.delete();
    tick; ScanReq = 0;
    repeat (10) tick;
    chk("t3_rd_beat2", dq[2], 6'h21);
    chk("t3_rd_beat5", dq[5], 6'h24);

    // Writer starvation limit against continuous scanout
    rdq.delete(); wrq.delete();
    ScanReq = 1; ScanAddr = 15'h0100; WrReq = 1; WrAddr = 15'h0AAA; WrData = 6'h15;
    ack_k = -1;
    for (int k = 0; k < 40 && ack_k < 0; k++) begin
      #1 if (WrAck) ack_k = k;
      tick;
    end
    WrReq = 0;
    chk("t4_wrack_cycle", ack_k, 16);
    repeat (20) tick;
    chk("t4_nwrites", wrq.size(), 1);
    chk("t4_write", wrq[0], {15'h0AAA, 6'h15});
    ScanReq = 0;
    repeat (12) tick;

    // Urgent scanout starves the writer; wait counter saturates
    ScanReq = 1; ScanUrgent = 1; WrReq = 1; WrAddr = 15'h0BBB; WrData = 6'h2A;
    nwack = 0; drops = 0;
    for (int k = 0; k < 48; k++) begin
      #1;
      if (WrAck) nwack++;
      if (k >= 2 && !ScanValid) drops++;
      tick;
    end
    chk("t5_no_wrack", nwack, 0);
    chk("t5_valid_drops", drops, 0);
    ScanUrgent = 0; ack_k = -1;
    for (int k = 0; k < 12 && ack_k < 0; k++) begin
      #1 if (WrAck) ack_k = k;
      tick;
    end
    WrReq = 0;
    chk("t5_sat_wrack", ack_k, 0);
    ScanReq = 0;
    repeat (12) tick;

    // Reset at beat 3 aborts the burst
    ScanReq = 1; ScanAddr = 15'h0200;
    #1 chk("t6_ack", ScanAck, 1);
    tick; ScanReq = 0;
    tick; tick; tick;
    nlast = 0;
    Reset = 1; ScanReq = 1;
    #1 chk("t6_ack_in_reset", ScanAck, 0);
    tick;
    chk("t6_memen_after_rst", MemEn, 0);
    chk("t6_valid_after_rst", ScanValid, 0);
    Reset = 0;
    #1 chk("t6_fresh_ack", ScanAck, 1);
    tick; ScanReq = 0;
    repeat (5) tick;
    chk("t6_no_last_aborted", nlast, 0);
    repeat (8) tick;
    chk("t6_last_fresh", nlast, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
